// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types and constants for the control_unit sequencer
//
// Purpose: state encoding, opcode class encoding, opcode values, the ALU
// increment bit and the IR field positions used by control_unit/cu_decode.
// Optional feature macro: CU_MULDIV_EN (MUL/DIV decode, T5 LO / T6 HI path).
package cu_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_T6   = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      CLS_BINARY  = 2'd0,
      CLS_MULDIV  = 2'd1,
      CLS_UNARY   = 2'd2,
      CLS_ILLEGAL = 2'd3
   } op_class_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   localparam int ALU_INC = 31;

   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 27;
   localparam int RA_HI     = 26;
   localparam int RA_LO     = 23;
   localparam int RB_HI     = 22;
   localparam int RB_LO     = 19;
   localparam int RC_HI     = 18;
   localparam int RC_LO     = 15;

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational IR decoder for control_unit
//
// Purpose: splits the IR into register fields, classifies the opcode and
// builds the one-hot ALU operation vector.
// Ports:
//   ir       in  32  instruction register contents
//   ra/rb/rc out 4   destination / first source / second source register
//   op_class out 2   binary, muldiv, unary or illegal
//   alu_op   out 32  one-hot, bit[opcode] set
// Optional feature macro: CU_MULDIV_EN (MUL/DIV classed as muldiv, else illegal).
module cu_decode
   import cu_pkg::*;
(
   input  logic [31:0] ir,
   output logic [3:0]  ra,
   output logic [3:0]  rb,
   output logic [3:0]  rc,
   output op_class_t   op_class,
   output logic [31:0] alu_op
);

   logic [4:0]  opcode;
   logic [14:0] unused_ir_bits;

   assign opcode         = ir[OPCODE_HI:OPCODE_LO];
   assign ra             = ir[RA_HI:RA_LO];
   assign rb             = ir[RB_HI:RB_LO];
   assign rc             = ir[RC_HI:RC_LO];
   assign unused_ir_bits = ir[14:0];

   // Only meaningful for legal opcodes; the sequencer never drives it otherwise.
   assign alu_op = 32'd1 << opcode;

   always_comb begin
      op_class = CLS_ILLEGAL;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  op_class = CLS_BINARY;
`ifdef CU_MULDIV_EN
         OP_MUL, OP_DIV:                   op_class = CLS_MULDIV;
`endif
         OP_NEG, OP_NOT:                   op_class = CLS_UNARY;
         default:                          op_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/execute sequencer driving the datapath
//
// Purpose: steps IDLE -> T0..T2 (fetch) -> T3..T6 (execute) and drives every
// datapath enable/select combinationally from the state register and ir.
// Ports:
//   clk, clr (async active-low reset), run, mem_ready, ir[31:0]
//   r_en/r_sel [NREG-1:0] one-hot register load / bus select
//   Pen Pselect MARen MDRen MDRselect IRen Yen Zen zlowselect Zhighselect
//   HIen LOen Read   single-bit datapath controls
//   alu_control[31:0] one-hot ALU op; busy, done, illegal status
// Optional feature macro: CU_MULDIV_EN (MUL/DIV with T5 LO and T6 HI writes;
// without it HIen/LOen are tied low and T6 is unreachable).
module control_unit
   import cu_pkg::*;
#(
   parameter int NREG = 16
)
(
   input  logic            clk,
   input  logic            clr,
   input  logic            run,
   input  logic            mem_ready,
   input  logic [31:0]     ir,
   output logic [NREG-1:0] r_en,
   output logic [NREG-1:0] r_sel,
   output logic            Pen,
   output logic            Pselect,
   output logic            MARen,
   output logic            MDRen,
   output logic            MDRselect,
   output logic            IRen,
   output logic            Yen,
   output logic            Zen,
   output logic            zlowselect,
   output logic            Zhighselect,
   output logic            HIen,
   output logic            LOen,
   output logic            Read,
   output logic [31:0]     alu_control,
   output logic            busy,
   output logic            done,
   output logic            illegal
);

   localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};
   localparam logic [31:0]     ALU_INC_VEC = 32'd1 << ALU_INC;

   state_t          state;
   state_t          state_nx;
   state_t          end_nx;
   logic [3:0]      ra;
   logic [3:0]      rb;
   logic [3:0]      rc;
   op_class_t       op_class;
   logic [31:0]     alu_op;
   logic [NREG-1:0] ra_hot;
   logic [NREG-1:0] rb_hot;
   logic [NREG-1:0] rc_hot;

   cu_decode u_decode (
      .ir       (ir),
      .ra       (ra),
      .rb       (rb),
      .rc       (rc),
      .op_class (op_class),
      .alu_op   (alu_op)
   );

   // Register numbers beyond NREG shift out, leaving the vector zero.
   assign ra_hot = ONE_HOT0 << ra;
   assign rb_hot = ONE_HOT0 << rb;
   assign rc_hot = ONE_HOT0 << rc;

   // Instruction end: run is sampled here, so a mid-instruction drop of run
   // only takes effect once the current instruction completes.
   assign end_nx = run ? S_T0 : S_IDLE;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= S_IDLE;
      else      state <= state_nx;
   end

   assign busy = (state != S_IDLE);

`ifdef CU_MULDIV_EN
   logic hi_en;
   logic lo_en;
   assign HIen = hi_en;
   assign LOen = lo_en;
`else
   assign HIen = 1'b0;
   assign LOen = 1'b0;
`endif

   always_comb begin
      state_nx    = state;
      r_en        = '0;
      r_sel       = '0;
      Pen         = 1'b0;
      Pselect     = 1'b0;
      MARen       = 1'b0;
      MDRen       = 1'b0;
      MDRselect   = 1'b0;
      IRen        = 1'b0;
      Yen         = 1'b0;
      Zen         = 1'b0;
      zlowselect  = 1'b0;
      Zhighselect = 1'b0;
      Read        = 1'b0;
      alu_control = '0;
      done        = 1'b0;
      illegal     = 1'b0;
`ifdef CU_MULDIV_EN
      hi_en       = 1'b0;
      lo_en       = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (run) state_nx = S_T0;
         end
         S_T0: begin
            Pselect     = 1'b1;
            MARen       = 1'b1;
            Zen         = 1'b1;
            alu_control = ALU_INC_VEC;
            state_nx    = S_T1;
         end
         S_T1: begin
            // PC reload from Z repeats during a stall; the value is unchanged.
            zlowselect = 1'b1;
            Pen        = 1'b1;
            Read       = 1'b1;
            MDRen      = 1'b1;
            if (mem_ready) state_nx = S_T2;
         end
         S_T2: begin
            MDRselect = 1'b1;
            IRen      = 1'b1;
            state_nx  = S_T3;
         end
         S_T3: begin
            case (op_class)
               CLS_ILLEGAL: begin
                  illegal  = 1'b1;
                  done     = 1'b1;
                  state_nx = end_nx;
               end
               CLS_UNARY: begin
                  r_sel       = rb_hot;
                  alu_control = alu_op;
                  Zen         = 1'b1;
                  state_nx    = S_T4;
               end
               default: begin
                  r_sel    = rb_hot;
                  Yen      = 1'b1;
                  state_nx = S_T4;
               end
            endcase
         end
         S_T4: begin
            if (op_class == CLS_UNARY) begin
               zlowselect = 1'b1;
               r_en       = ra_hot;
               done       = 1'b1;
               state_nx   = end_nx;
            end else begin
               r_sel       = rc_hot;
               alu_control = alu_op;
               Zen         = 1'b1;
               state_nx    = S_T5;
            end
         end
         S_T5: begin
            zlowselect = 1'b1;
`ifdef CU_MULDIV_EN
            if (op_class == CLS_MULDIV) begin
               lo_en    = 1'b1;
               state_nx = S_T6;
            end else begin
               r_en     = ra_hot;
               done     = 1'b1;
               state_nx = end_nx;
            end
`else
            r_en     = ra_hot;
            done     = 1'b1;
            state_nx = end_nx;
`endif
         end
`ifdef CU_MULDIV_EN
         S_T6: begin
            Zhighselect = 1'b1;
            hi_en       = 1'b1;
            done        = 1'b1;
            state_nx    = end_nx;
         end
`endif
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit
module tb_control_unit;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        run = 1'b0;
   logic        mem_ready = 1'b1;
   logic [31:0] ir = '0;
   logic [15:0] r_en, r_sel;
   logic        Pen, Pselect, MARen, MDRen, MDRselect, IRen, Yen, Zen;
   logic        zlowselect, Zhighselect, HIen, LOen, Read;
   logic [31:0] alu_control;
   logic        busy, done, illegal;

   control_unit #(.NREG(16)) dut (
      .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
      .r_en(r_en), .r_sel(r_sel), .Pen(Pen), .Pselect(Pselect), .MARen(MARen),
      .MDRen(MDRen), .MDRselect(MDRselect), .IRen(IRen), .Yen(Yen), .Zen(Zen),
      .zlowselect(zlowselect), .Zhighselect(Zhighselect), .HIen(HIen),
      .LOen(LOen), .Read(Read), .alu_control(alu_control), .busy(busy),
      .done(done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] r_en;
      logic [15:0] r_sel;
      logic Pen, Pselect, MARen, MDRen, MDRselect, IRen, Yen, Zen;
      logic zl, zh, HIen, LOen, Read;
      logic [31:0] alu;
      logic busy, done, illegal;
   } outs_t;

   typedef struct packed {
      outs_t       o;
      logic        mr;
      logic        rn;
      logic [31:0] irv;
   } ent_t;

   outs_t act;
   assign act = {r_en, r_sel, Pen, Pselect, MARen, MDRen, MDRselect, IRen, Yen, Zen,
                 zlowselect, Zhighselect, HIen, LOen, Read, alu_control, busy, done, illegal};

   ent_t sb[$];
   int   errors = 0;
   int   checks = 0;

   localparam logic [31:0] IR_ADD = 32'h1891_8000;
   localparam logic [31:0] IR_NOT = 32'h9090_0000;
   localparam logic [31:0] IR_MUL = 32'h7810_0000;
   localparam logic [31:0] IR_ILL = 32'hF800_0000;

   function automatic logic [15:0] hot(input logic [3:0] n);
      return 16'd1 << n;
   endfunction

   task automatic push(input outs_t o, input logic mr, input logic rn, input logic [31:0] i);
      ent_t e;
      e.o      = o;
      e.o.busy = 1'b1;
      e.mr     = mr;
      e.rn     = rn;
      e.irv    = i;
      sb.push_back(e);
   endtask

   // Reference sequence: one entry per cycle from T0 to the instruction's last state.
   task automatic push_instr(input logic [31:0] i, input int stalls, input logic run_after);
      logic [4:0] opc;
      int         cls;
      outs_t      o;
      logic [31:0] op;
      opc = i[31:27];
      op  = 32'd1 << opc;
      if (opc >= 5'd3 && opc <= 5'd11) cls = 0;
`ifdef CU_MULDIV_EN
      else if (opc == 5'd15 || opc == 5'd16) cls = 1;
`endif
      else if (opc == 5'd17 || opc == 5'd18) cls = 2;
      else cls = 3;
      o = '0; o.Pselect = 1; o.MARen = 1; o.Zen = 1; o.alu = 32'h8000_0000;
      push(o, 1'b1, 1'b1, i);
      for (int k = 0; k <= stalls; k++) begin
         o = '0; o.zl = 1; o.Pen = 1; o.Read = 1; o.MDRen = 1;
         push(o, (k == stalls), 1'b1, i);
      end
      o = '0; o.MDRselect = 1; o.IRen = 1;
      push(o, 1'b1, 1'b1, i);
      if (cls == 3) begin
         o = '0; o.illegal = 1; o.done = 1;
         push(o, 1'b1, run_after, i);
         return;
      end
      o = '0; o.r_sel = hot(i[22:19]);
      if (cls == 2) begin o.alu = op; o.Zen = 1; end
      else o.Yen = 1;
      push(o, 1'b1, 1'b1, i);
      if (cls == 2) begin
         o = '0; o.zl = 1; o.r_en = hot(i[26:23]); o.done = 1;
         push(o, 1'b1, run_after, i);
         return;
      end
      o = '0; o.r_sel = hot(i[18:15]); o.alu = op; o.Zen = 1;
      push(o, 1'b1, 1'b1, i);
      if (cls == 0) begin
         o = '0; o.zl = 1; o.r_en = hot(i[26:23]); o.done = 1;
         push(o, 1'b1, run_after, i);
         return;
      end
      o = '0; o.zl = 1; o.LOen = 1;
      push(o, 1'b1, 1'b1, i);
      o = '0; o.zh = 1; o.HIen = 1; o.done = 1;
      push(o, 1'b1, run_after, i);
   endtask

   task automatic start(input logic [31:0] i);
      ir = i; run = 1'b1; mem_ready = 1'b1;
   endtask

   task automatic test_reset;
      clr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         run = 1'($urandom); mem_ready = 1'($urandom); ir = $urandom;
         #1;
         checks++;
         if (act !== '0) begin errors++; $display("FAIL reset_outs k%0d: got %h want 0", k, act); end
      end
      @(negedge clk);
      run = 1'b0; clr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || act !== '0) begin
            errors++; $display("FAIL idle_after_reset k%0d: busy %b outs %h want 0", k, busy, act);
         end
      end
   endtask

   task automatic test_add;
      ent_t e;
      int   n = 0;
      start(IR_ADD);
      push_instr(IR_ADD, 0, 1'b0);
      checks++;
      if (sb.size() != 6) begin errors++; $display("FAIL add_len: got %0d want 6", sb.size()); end
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (act !== e.o) begin errors++; $display("FAIL add cyc%0d: got %h want %h", n, act, e.o); end
         mem_ready = e.mr; run = e.rn; ir = e.irv; n++;
      end
      @(negedge clk); checks++;
      if (act !== '0) begin errors++; $display("FAIL add_idle: got %h want 0", act); end
   endtask

   task automatic test_not_stall;
      ent_t e;
      int   n = 0;
      start(IR_NOT);
      push_instr(IR_NOT, 3, 1'b0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (act !== e.o) begin errors++; $display("FAIL not_stall cyc%0d: got %h want %h", n, act, e.o); end
         mem_ready = e.mr; run = e.rn; ir = e.irv; n++;
      end
      checks++;
      if (n != 8) begin errors++; $display("FAIL not_len: got %0d want 8", n); end
      @(negedge clk); checks++;
      if (act !== '0) begin errors++; $display("FAIL not_idle: got %h want 0", act); end
   endtask

   task automatic test_mul;
      ent_t e;
      int   n = 0;
      start(IR_MUL);
      push_instr(IR_MUL, 0, 1'b0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (act !== e.o) begin errors++; $display("FAIL mul cyc%0d: got %h want %h", n, act, e.o); end
         mem_ready = e.mr; run = e.rn; ir = e.irv; n++;
      end
      @(negedge clk); checks++;
      if (act !== '0) begin errors++; $display("FAIL mul_idle: got %h want 0", act); end
   endtask

   task automatic test_illegal;
      ent_t e;
      int   n = 0;
      start(IR_ILL);
      push_instr(IR_ILL, 0, 1'b1);
      push_instr(IR_ADD, 1, 1'b0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (act !== e.o) begin errors++; $display("FAIL illegal cyc%0d: got %h want %h", n, act, e.o); end
         mem_ready = e.mr; run = e.rn; ir = e.irv; n++;
      end
      @(negedge clk); checks++;
      if (act !== '0) begin errors++; $display("FAIL illegal_idle: got %h want 0", act); end
   endtask

   task automatic test_back_to_back;
      ent_t e;
      int   n = 0;
      start(IR_NOT);
      push_instr(IR_NOT, 0, 1'b1);
      push_instr(IR_MUL, 2, 1'b1);
      push_instr(IR_ADD, 0, 1'b0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (act !== e.o) begin errors++; $display("FAIL b2b cyc%0d: got %h want %h", n, act, e.o); end
         mem_ready = e.mr; run = e.rn; ir = e.irv; n++;
      end
      @(negedge clk); checks++;
      if (act !== '0) begin errors++; $display("FAIL b2b_idle: got %h want 0", act); end
   endtask

   task automatic test_clr_mid;
      ent_t e;
      int   n = 0;
      start(IR_ADD);
      push_instr(IR_ADD, 0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (act !== e.o) begin errors++; $display("FAIL clr_pre cyc%0d: got %h want %h", k, act, e.o); end
         mem_ready = e.mr; run = e.rn; ir = e.irv;
      end
      #1 clr = 1'b0;
      #1; checks++;
      if (act !== '0) begin errors++; $display("FAIL clr_async: got %h want 0", act); end
      sb.delete();
      @(negedge clk); checks++;
      if (act !== '0) begin errors++; $display("FAIL clr_hold: got %h want 0", act); end
      clr = 1'b1;
      start(IR_ADD);
      push_instr(IR_ADD, 0, 1'b0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (act !== e.o) begin errors++; $display("FAIL clr_restart cyc%0d: got %h want %h", n, act, e.o); end
         mem_ready = e.mr; run = e.rn; ir = e.irv; n++;
      end
      @(negedge clk); checks++;
      if (act !== '0) begin errors++; $display("FAIL clr_idle: got %h want 0", act); end
   endtask

   initial begin
      #2;
      test_reset();
      test_add();
      test_not_stall();
      test_mul();
      test_illegal();
      test_back_to_back();
      test_clr_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
